// File: rtl/hdmi_frame_reader_if.sv
// Frame-buffer read port and encoder-side video bus of the HDMI scan-out stage.
// master = hdmi_frame_reader, slave = frame-buffer read port plus TMDS encoder.
interface hdmi_frame_reader_if;
    logic        ord_en;
    logic [18:0] oraddr;
    logic [23:0] ird_data;
    logic [23:0] orgb;
    logic        ode;
    logic        ohsync;
    logic        ovsync;
    logic        oframe_start;

    modport master (
        output ord_en, oraddr, orgb, ode, ohsync, ovsync, oframe_start,
        input  ird_data
    );

    modport slave (
        input  ord_en, oraddr, orgb, ode, ohsync, ovsync, oframe_start,
        output ird_data
    );
endinterface

// File: rtl/hdmi_frame_reader.sv
// 640x480@60 scan-out: video timing, linear frame-buffer reads, sync/de aligned to read data.
// Optional colour-bar generator is built only when HDMI_TEST_PATTERN_EN is defined.
module hdmi_frame_reader #(
    parameter int RD_LAT       = 2,
    parameter int FRAME_PIXELS = 307200,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33
) (
    input  logic                 iclk,
    input  logic                 ireset,
    input  logic                 ienable,
    input  logic                 itest_pattern,
    hdmi_frame_reader_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_END     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_END     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0]  H_SYNC_LO = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_SYNC_LO = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0] ADDR_LAST = 19'(FRAME_PIXELS - 1);

    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [18:0] addr;
    logic        frame_en;

    logic active;
    logic frame_end;
    logic hsync_n;
    logic vsync_n;
    logic first_pixel;
    logic pattern;
    logic read;

    // Stage-0 flags; index RD_LAT lines up with ird_data
    logic [RD_LAT:0] dl_active;
    logic [RD_LAT:0] dl_read;
    logic [RD_LAT:0] dl_hsync;
    logic [RD_LAT:0] dl_vsync;
    logic [RD_LAT:0] dl_first;
    logic [23:0]     pixel;

    always_comb begin
        active      = (hcnt < H_ACT) && (vcnt < V_ACT);
        frame_end   = (hcnt == H_END) && (vcnt == V_END);
        hsync_n     = !((hcnt >= H_SYNC_LO) && (hcnt < H_SYNC_HI));
        vsync_n     = !((vcnt >= V_SYNC_LO) && (vcnt < V_SYNC_HI));
        first_pixel = (hcnt == 10'd0) && (vcnt == 10'd0);
        read        = active && frame_en && !pattern;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            hcnt       <= 10'd0;
            vcnt       <= 10'd0;
            addr       <= 19'd0;
            frame_en   <= 1'b0;
            bus.ord_en <= 1'b0;
            bus.oraddr <= 19'd0;
        end else begin
            if (hcnt == H_END) begin
                hcnt <= 10'd0;
                vcnt <= (vcnt == V_END) ? 10'd0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end

            // Address advances on every active pixel so it stays tied to screen position
            // even if the pattern select toggles mid-frame.
            if (frame_end) begin
                frame_en <= ienable;
                addr     <= 19'd0;
            end else if (active && (addr != ADDR_LAST)) begin
                addr <= addr + 19'd1;
            end

            bus.ord_en <= read;
            if (read)
                bus.oraddr <= addr;
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            dl_active <= '0;
            dl_read   <= '0;
            dl_hsync  <= '1;
            dl_vsync  <= '1;
            dl_first  <= '0;
        end else begin
            dl_active <= {dl_active[RD_LAT-1:0], active};
            dl_read   <= {dl_read[RD_LAT-1:0], read};
            dl_hsync  <= {dl_hsync[RD_LAT-1:0], hsync_n};
            dl_vsync  <= {dl_vsync[RD_LAT-1:0], vsync_n};
            dl_first  <= {dl_first[RD_LAT-1:0], first_pixel};
        end
    end

`ifdef HDMI_TEST_PATTERN_EN
    logic [2:0]      bar;
    logic [RD_LAT:0] dl_pat;
    logic [2:0]      dl_bar [RD_LAT+1];

    assign pattern = itest_pattern;

    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++)
            if (hcnt >= 10'(k * H_ACTIVE / 8))
                bar = 3'(k);
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            dl_pat <= '0;
            for (int k = 0; k <= RD_LAT; k++)
                dl_bar[k] <= 3'd0;
        end else begin
            dl_pat    <= {dl_pat[RD_LAT-1:0], itest_pattern && active};
            dl_bar[0] <= bar;
            for (int k = 1; k <= RD_LAT; k++)
                dl_bar[k] <= dl_bar[k-1];
        end
    end

    // Bar order white..black maps to R=~b[1], G=~b[2], B=~b[0]
    always_comb begin
        pixel = dl_read[RD_LAT] ? bus.ird_data : 24'h0;
        if (dl_pat[RD_LAT])
            pixel = {{8{~dl_bar[RD_LAT][1]}}, {8{~dl_bar[RD_LAT][2]}}, {8{~dl_bar[RD_LAT][0]}}};
    end
`else
    logic unused_pattern;

    assign pattern        = 1'b0;
    assign unused_pattern = itest_pattern;

    always_comb begin
        pixel = dl_read[RD_LAT] ? bus.ird_data : 24'h0;
    end
`endif

    always_ff @(posedge iclk) begin
        if (ireset) begin
            bus.orgb         <= 24'h0;
            bus.ode          <= 1'b0;
            bus.ohsync       <= 1'b1;
            bus.ovsync       <= 1'b1;
            bus.oframe_start <= 1'b0;
        end else begin
            bus.orgb         <= pixel;
            bus.ode          <= dl_active[RD_LAT];
            bus.ohsync       <= dl_hsync[RD_LAT];
            bus.ovsync       <= dl_vsync[RD_LAT];
            bus.oframe_start <= dl_first[RD_LAT];
        end
    end
endmodule

// File: tb/tb_hdmi_frame_reader.sv
// Bench for hdmi_frame_reader: four instances (RD_LAT 1..4) on a scaled-down raster,
// each fed by a latency-matched memory returning its address, compared against a position model.
module tb_hdmi_frame_reader;
    localparam int HA  = 32;
    localparam int HFP = 4;
    localparam int HSY = 8;
    localparam int HBP = 4;
    localparam int VA  = 12;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FP  = HA * VA;
    localparam int FT  = HT * VT;
    localparam int MAXC = 32768;

    // {rgb, de, hsync, vsync, frame_start}
    localparam logic [27:0] BLANK = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic tp  = 1'b0;

    always #5 clk = ~clk;

    logic [3:0][27:0] out_w;
    logic [3:0][19:0] rd_w;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        hdmi_frame_reader_if bus ();
        logic [23:0] pipe [g+1];

        hdmi_frame_reader #(
            .RD_LAT(g + 1), .FRAME_PIXELS(FP),
            .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
            .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
        ) dut (
            .iclk(clk),
            .ireset(rst),
            .ienable(en),
            .itest_pattern(tp),
            .bus(bus)
        );

        // Unrequested reads return junk so any ungated pixel shows up
        always @(posedge clk) begin
            pipe[0] <= bus.ord_en ? {5'b0, bus.oraddr} : 24'($urandom);
            for (int k = 1; k <= g; k++)
                pipe[k] <= pipe[k-1];
        end

        assign bus.ird_data = pipe[g];
        assign out_w[g] = {bus.orgb, bus.ode, bus.ohsync, bus.ovsync, bus.oframe_start};
        assign rd_w[g]  = {bus.ord_en, bus.oraddr};
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int pos = 0;
    int last_rst = -1000;
    int hold_addr = 0;
    bit fen = 1'b0;
    bit started = 1'b0;
    bit count_on = 1'b0;
    int hs_lo [4];
    int vs_lo [4];
    int de_hi [4];

    logic [27:0] hist_out  [MAXC];
    bit          hist_en   [MAXC];
    int          hist_addr [MAXC];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit t);
        logic [19:0] exp_rd;
        logic [27:0] exp_out;
        logic [23:0] rgb;
        int s, x, y;
        bit act, hs, vs, pat, rde;

        @(negedge clk);
        if (cyc >= MAXC) begin
            $display("FAIL history overflow at cycle %0d", cyc);
            $fatal(1);
        end
        if (started) begin
            if (last_rst == cyc - 1) begin
                exp_rd = 20'h0;
                hold_addr = 0;
            end else if (hist_en[cyc-1]) begin
                exp_rd = {1'b1, 19'(hist_addr[cyc-1])};
                hold_addr = hist_addr[cyc-1];
            end else begin
                exp_rd = {1'b0, 19'(hold_addr)};
            end
            for (int g = 0; g < 4; g++) begin
                check($sformatf("rd_lat%0d", g + 1), 32'(rd_w[g]), 32'(exp_rd));
                s = cyc - (g + 1) - 2;
                if (last_rst >= s) exp_out = BLANK;
                else               exp_out = hist_out[s];
                check($sformatf("out_lat%0d", g + 1), 32'(out_w[g]), 32'(exp_out));
                if (count_on) begin
                    hs_lo[g] += int'(!out_w[g][2]);
                    vs_lo[g] += int'(!out_w[g][1]);
                    de_hi[g] += int'(out_w[g][3]);
                end
            end
        end

        rst = r;
        en  = e;
        tp  = t;

        x   = pos % HT;
        y   = pos / HT;
        act = (x < HA) && (y < VA);
        hs  = !((x >= HA + HFP) && (x < HA + HFP + HSY));
        vs  = !((y >= VA + VFP) && (y < VA + VFP + VSY));
`ifdef HDMI_TEST_PATTERN_EN
        pat = t && act;
`else
        pat = 1'b0;
`endif
        rde = act && fen && !pat;
        if (pat)      rgb = BARS[x * 8 / HA];
        else if (rde) rgb = 24'(y * HA + x);
        else          rgb = 24'h0;
        hist_out[cyc]  = {rgb, act, hs, vs, pos == 0};
        hist_en[cyc]   = rde;
        hist_addr[cyc] = y * HA + x;

        if (r) begin
            last_rst = cyc;
            pos = 0;
            fen = 1'b0;
            started = 1'b1;
        end else if (pos == FT - 1) begin
            pos = 0;
            fen = e;
        end else begin
            pos++;
        end
        cyc++;
    endtask

    initial begin
        bit e_r, t_r, r_r;

        for (int g = 0; g < 4; g++) begin
            hs_lo[g] = 0;
            vs_lo[g] = 0;
            de_hi[g] = 0;
        end

        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (FT) step(1'b0, 1'b1, 1'b0);

        count_on = 1'b1;
        repeat (FT) step(1'b0, 1'b1, 1'b0);
        count_on = 1'b0;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("hsync_low_lat%0d", g + 1), 32'(hs_lo[g]), 32'(HSY * VT));
            check($sformatf("vsync_low_lat%0d", g + 1), 32'(vs_lo[g]), 32'(VSY * HT));
            check($sformatf("de_high_lat%0d", g + 1),   32'(de_hi[g]), 32'(HA * VA));
        end

        // enable dropped and later raised mid-frame
        for (int i = 0; i < FT && pos != FT / 2; i++) step(1'b0, 1'b1, 1'b0);
        repeat (FT + FT / 2) step(1'b0, 1'b0, 1'b0);
        repeat (2 * FT + FT / 2) step(1'b0, 1'b1, 1'b0);

        // single-cycle reset in the middle of active video
        for (int i = 0; i < FT && pos != 6 * HT + 20; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (2 * FT) step(1'b0, 1'b1, 1'b0);

        // pattern select held for a frame, then random enable/pattern/reset activity
        repeat (FT) step(1'b0, 1'b1, 1'b1);
        e_r = 1'b1;
        t_r = 1'b0;
        repeat (9 * FT) begin
            if ($urandom_range(299) == 0) e_r = !e_r;
            if ($urandom_range(149) == 0) t_r = !t_r;
            r_r = ($urandom_range(3999) == 0);
            step(r_r, e_r, t_r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
